// File: rtl/sdram_responder_if.sv
// Pin bus between an SDR SDRAM controller (master) and the responder (slave).
interface sdram_responder_if;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic [3:0]  dqm;
  logic [31:0] dq_in;
  logic [31:0] dq_out;
  logic        dq_oe;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm, dq_in,
    input  dq_out, dq_oe
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm, dq_in,
    output dq_out, dq_oe
  );
endinterface

// File: rtl/sdram_responder.sv
// SDR SDRAM device emulator: decodes controller commands, stores words in an
// internal RAM and returns read data after the programmed CAS latency.
module sdram_responder #(
  parameter int ROW_BITS   = 2,
  parameter int COL_BITS   = 4,
  parameter int CL_DEFAULT = 2
) (
  input  logic             clock_50mhz,
  input  logic             pin_reset,
  sdram_responder_if.slave bus,
  output logic [3:0]       bank_open,
  output logic [1:0]       cas_latency,
  output logic [15:0]      refresh_count,
  output logic             err_protocol
);

  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;

  typedef enum logic [2:0] {
    CMD_LOAD_MODE  = 3'b000,
    CMD_REFRESH    = 3'b001,
    CMD_PRECHARGE  = 3'b010,
    CMD_ACTIVE     = 3'b011,
    CMD_WRITE      = 3'b100,
    CMD_READ       = 3'b101,
    CMD_BURST_STOP = 3'b110,
    CMD_NOP        = 3'b111
  } cmd_t;

  logic [31:0]         mem [DEPTH];
  logic [12:0]         open_row [4];
  logic [12:0]         sel_row;
  logic [IDX_BITS-1:0] idx;
  logic [31:0]         rd_mask;
  logic [31:0]         rd_word;
  cmd_t                cmd;

  logic [3:0]  bank_open_d;
  logic [1:0]  cl_d;
  logic [15:0] refresh_d;
  logic        err_d;
  logic        row_load;
  logic        rd_issue;
  logic        wr_en;
  logic        rd_cl3;

  logic        s0_valid, s1_valid;
  logic [31:0] s0_data, s1_data;
  logic [31:0] dq_out_q;
  logic        dq_oe_q;
  logic        unused_rows;

  assign bus.dq_out = dq_out_q;
  assign bus.dq_oe  = dq_oe_q;

  always_comb begin
    cmd         = cmd_t'({bus.ras_n, bus.cas_n, bus.we_n});
    sel_row     = open_row[bus.ba];
    idx         = {bus.ba, sel_row[ROW_BITS-1:0], bus.addr[COL_BITS-1:0]};
    rd_mask     = {{8{~bus.dqm[3]}}, {8{~bus.dqm[2]}}, {8{~bus.dqm[1]}}, {8{~bus.dqm[0]}}};
    rd_word     = mem[idx] & rd_mask;
    rd_cl3      = (cas_latency == 2'd3);
    unused_rows = ^{open_row[0], open_row[1], open_row[2], open_row[3]};
  end

  always_comb begin
    bank_open_d = bank_open;
    cl_d        = cas_latency;
    refresh_d   = refresh_count;
    err_d       = 1'b0;
    row_load    = 1'b0;
    rd_issue    = 1'b0;
    wr_en       = 1'b0;
    if (bus.cke && !bus.cs_n) begin
      case (cmd)
        CMD_ACTIVE: begin
          if (bank_open[bus.ba]) err_d = 1'b1;
          else begin
            bank_open_d[bus.ba] = 1'b1;
            row_load            = 1'b1;
          end
        end
        CMD_READ: begin
          if (!bank_open[bus.ba]) err_d = 1'b1;
          else begin
            rd_issue = 1'b1;
            if (bus.addr[10]) bank_open_d[bus.ba] = 1'b0;
          end
        end
        CMD_WRITE: begin
          // A write while read data is on the bus is flagged but still performed.
          if (dq_oe_q) err_d = 1'b1;
          if (!bank_open[bus.ba]) err_d = 1'b1;
          else begin
            wr_en = 1'b1;
            if (bus.addr[10]) bank_open_d[bus.ba] = 1'b0;
          end
        end
        CMD_PRECHARGE: begin
          if (bus.addr[10]) bank_open_d = '0;
          else bank_open_d[bus.ba] = 1'b0;
        end
        CMD_REFRESH: begin
          if (|bank_open) err_d = 1'b1;
          else refresh_d = refresh_count + 16'd1;
        end
        CMD_LOAD_MODE: begin
          if (|bank_open) err_d = 1'b1;
          else if (bus.addr[6:4] == 3'd2 || bus.addr[6:4] == 3'd3) cl_d = bus.addr[5:4];
          else err_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Storage and read data path carry no reset so memory survives pin_reset.
  always_ff @(posedge clock_50mhz) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!bus.dqm[i]) mem[idx][8*i +: 8] <= bus.dq_in[8*i +: 8];
      end
    end
    s0_data <= rd_word;
    s1_data <= (rd_issue && !rd_cl3) ? rd_word : s0_data;
  end

  // CL3 reads enter stage 0, CL2 reads skip straight to stage 1.
  always_ff @(posedge clock_50mhz or negedge pin_reset) begin
    if (!pin_reset) begin
      bank_open     <= '0;
      cas_latency   <= 2'(CL_DEFAULT);
      refresh_count <= '0;
      err_protocol  <= 1'b0;
      s0_valid      <= 1'b0;
      s1_valid      <= 1'b0;
      dq_oe_q       <= 1'b0;
      dq_out_q      <= '0;
      for (int unsigned b = 0; b < 4; b++) open_row[b] <= '0;
    end else begin
      bank_open     <= bank_open_d;
      cas_latency   <= cl_d;
      refresh_count <= refresh_d;
      err_protocol  <= err_d;
      s0_valid      <= rd_issue && rd_cl3;
      s1_valid      <= (rd_issue && !rd_cl3) || s0_valid;
      dq_oe_q       <= s1_valid;
      if (s1_valid) dq_out_q <= s1_data;
      if (row_load) open_row[bus.ba] <= bus.addr;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder.
module tb_sdram_responder;

  localparam logic [2:0] LOAD = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                         WR = 3'b100, RD = 3'b101, NOP = 3'b111;

  logic        clock_50mhz;
  logic        pin_reset;
  logic [3:0]  bank_open;
  logic [1:0]  cas_latency;
  logic [15:0] refresh_count;
  logic        err_protocol;
  int          errors;
  int          checks;
  logic [31:0] four_exp [4];

  sdram_responder_if bus ();

  sdram_responder #(.ROW_BITS(2), .COL_BITS(4), .CL_DEFAULT(2)) dut (
    .clock_50mhz   (clock_50mhz),
    .pin_reset     (pin_reset),
    .bus           (bus),
    .bank_open     (bank_open),
    .cas_latency   (cas_latency),
    .refresh_count (refresh_count),
    .err_protocol  (err_protocol)
  );

  initial clock_50mhz = 1'b0;
  always #10 clock_50mhz = ~clock_50mhz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one command for one rising edge; returns 1ns after that edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    @(negedge clock_50mhz);
    bus.cke = 1'b1;
    bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = c;
    bus.ba = b;
    bus.addr = a;
    bus.dqm = m;
    bus.dq_in = d;
    @(posedge clock_50mhz);
    #1;
  endtask

  task automatic nop();
    issue(NOP, 2'd0, 13'd0, 4'd0, 32'd0);
  endtask

  task automatic read_expect(input logic [1:0] b, input logic [12:0] a, input logic [3:0] m,
                             input int cl, input logic [31:0] exp, input string tag);
    issue(RD, b, a, m, 32'd0);
    check({tag, " oe early"}, 32'(bus.dq_oe), 32'd0);
    for (int k = 0; k < cl - 2; k++) begin
      nop();
      check({tag, " oe early"}, 32'(bus.dq_oe), 32'd0);
    end
    nop();
    check({tag, " oe due"}, 32'(bus.dq_oe), 32'd1);
    check({tag, " data"}, bus.dq_out, exp);
    nop();
    check({tag, " oe after"}, 32'(bus.dq_oe), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pin_reset = 1'b0;
    bus.cke = 1'b1; bus.cs_n = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    bus.ba = '0; bus.addr = '0; bus.dqm = '0; bus.dq_in = '0;
    repeat (2) @(posedge clock_50mhz);
    #1;
    check("rst dq_oe", 32'(bus.dq_oe), 32'd0);
    check("rst dq_out", bus.dq_out, 32'd0);
    check("rst bank_open", 32'(bank_open), 32'd0);
    check("rst cl", 32'(cas_latency), 32'd2);
    check("rst refresh", 32'(refresh_count), 32'd0);
    check("rst err", 32'(err_protocol), 32'd0);
    @(negedge clock_50mhz);
    pin_reset = 1'b1;

    issue(LOAD, 2'd0, 13'h020, 4'd0, 32'd0);
    check("mode cl2", 32'(cas_latency), 32'd2);
    check("mode err", 32'(err_protocol), 32'd0);
    issue(ACT, 2'd0, 13'h001, 4'd0, 32'd0);
    check("act b0", 32'(bank_open), 32'd1);
    issue(WR, 2'd0, 13'h001, 4'd0, 32'h0F0F0F0F);
    check("wr err", 32'(err_protocol), 32'd0);
    read_expect(2'd0, 13'h001, 4'd0, 2, 32'h0F0F0F0F, "cl2 rd");
    check("cl2 hold", bus.dq_out, 32'h0F0F0F0F);
    check("cl2 err", 32'(err_protocol), 32'd0);

    issue(PRE, 2'd0, 13'h000, 4'd0, 32'd0);
    check("pre b0", 32'(bank_open), 32'd0);
    issue(LOAD, 2'd0, 13'h030, 4'd0, 32'd0);
    check("mode cl3", 32'(cas_latency), 32'd3);
    check("mode3 err", 32'(err_protocol), 32'd0);
    issue(ACT, 2'd0, 13'h001, 4'd0, 32'd0);
    read_expect(2'd0, 13'h001, 4'd0, 3, 32'h0F0F0F0F, "cl3 rd");

    four_exp[0] = 32'hC0C00000;
    four_exp[1] = 32'h0F0F0F0F;
    four_exp[2] = 32'hC0C00002;
    four_exp[3] = 32'hC0C00003;
    issue(WR, 2'd0, 13'h000, 4'd0, 32'hC0C00000);
    issue(WR, 2'd0, 13'h002, 4'd0, 32'hC0C00002);
    issue(WR, 2'd0, 13'h003, 4'd0, 32'hC0C00003);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) issue(RD, 2'd0, 13'(i), 4'd0, 32'd0);
      else nop();
      if (i >= 2) begin
        check("burst oe", 32'(bus.dq_oe), 32'd1);
        check("burst data", bus.dq_out, four_exp[i-2]);
      end else begin
        check("burst oe early", 32'(bus.dq_oe), 32'd0);
      end
    end
    nop();
    check("burst oe end", 32'(bus.dq_oe), 32'd0);

    issue(WR, 2'd0, 13'h005, 4'd0, 32'hAABBCCDD);
    issue(WR, 2'd0, 13'h005, 4'b0101, 32'h11223344);
    read_expect(2'd0, 13'h005, 4'd0, 3, 32'h11BB33DD, "wmask");
    read_expect(2'd0, 13'h005, 4'b1000, 3, 32'h00BB33DD, "rmask");

    issue(RD, 2'd0, 13'h001, 4'd0, 32'd0);
    nop();
    nop();
    check("coll oe", 32'(bus.dq_oe), 32'd1);
    issue(WR, 2'd0, 13'h007, 4'd0, 32'h5555AAAA);
    check("coll err", 32'(err_protocol), 32'd1);
    check("coll data", bus.dq_out, 32'h0F0F0F0F);
    nop();
    check("coll err clr", 32'(err_protocol), 32'd0);
    read_expect(2'd0, 13'h007, 4'd0, 3, 32'h5555AAAA, "coll wr");

    issue(RD, 2'd2, 13'h001, 4'd0, 32'd0);
    check("idle rd err", 32'(err_protocol), 32'd1);
    for (int i = 0; i < 3; i++) begin
      nop();
      check("idle rd oe", 32'(bus.dq_oe), 32'd0);
    end
    check("idle rd err clr", 32'(err_protocol), 32'd0);

    issue(ACT, 2'd0, 13'h002, 4'd0, 32'd0);
    check("dbl act err", 32'(err_protocol), 32'd1);
    check("dbl act bank", 32'(bank_open), 32'd1);
    read_expect(2'd0, 13'h005, 4'd0, 3, 32'h11BB33DD, "dbl act row");

    issue(PRE, 2'd0, 13'h000, 4'd0, 32'd0);
    issue(LOAD, 2'd0, 13'h050, 4'd0, 32'd0);
    check("bad cl err", 32'(err_protocol), 32'd1);
    check("bad cl keep", 32'(cas_latency), 32'd3);

    issue(ACT, 2'd0, 13'h001, 4'd0, 32'd0);
    issue(REF, 2'd0, 13'h000, 4'd0, 32'd0);
    check("ref open err", 32'(err_protocol), 32'd1);
    check("ref open cnt", 32'(refresh_count), 32'd0);

    issue(WR, 2'd0, 13'h406, 4'd0, 32'h66666666);
    check("wr ap bank", 32'(bank_open), 32'd0);
    check("wr ap err", 32'(err_protocol), 32'd0);

    issue(ACT, 2'd1, 13'h000, 4'd0, 32'd0);
    issue(ACT, 2'd3, 13'h000, 4'd0, 32'd0);
    check("act b1 b3", 32'(bank_open), 32'hA);
    issue(PRE, 2'd0, 13'h400, 4'd0, 32'd0);
    check("pre all", 32'(bank_open), 32'd0);

    repeat (3) issue(REF, 2'd0, 13'h000, 4'd0, 32'd0);
    check("ref cnt", 32'(refresh_count), 32'd3);
    check("ref err", 32'(err_protocol), 32'd0);

    issue(ACT, 2'd0, 13'h001, 4'd0, 32'd0);
    issue(RD, 2'd0, 13'h001, 4'd0, 32'd0);
    @(negedge clock_50mhz);
    pin_reset = 1'b0;
    {bus.ras_n, bus.cas_n, bus.we_n} = NOP;
    @(posedge clock_50mhz);
    #1;
    check("mid rst oe", 32'(bus.dq_oe), 32'd0);
    check("mid rst bank", 32'(bank_open), 32'd0);
    check("mid rst cl", 32'(cas_latency), 32'd2);
    @(negedge clock_50mhz);
    pin_reset = 1'b1;
    @(posedge clock_50mhz);
    #1;
    check("post rst oe", 32'(bus.dq_oe), 32'd0);
    nop();
    check("post rst oe2", 32'(bus.dq_oe), 32'd0);

    issue(ACT, 2'd0, 13'h001, 4'd0, 32'd0);
    read_expect(2'd0, 13'h006, 4'd0, 2, 32'h66666666, "keep ap");
    read_expect(2'd0, 13'h001, 4'd0, 2, 32'h0F0F0F0F, "keep c1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
